// File: rtl/conv_cache_pkg.sv
// Shared definitions for conv_pixel_window_cache: FSM state encoding and
// index helpers used to size ports and place window elements.
package conv_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STALL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Bit offset of window element (row, col); the top-left element lands in the MSBs.
    function automatic int win_offset(input int row, input int col, input int ker_w, input int data_w);
        return (ker_w * ker_w - 1 - (row * ker_w + col)) * data_w;
    endfunction

endpackage

// File: rtl/conv_line_shift_buffer.sv
// Shift-register line buffer: stage 0 holds the most recently shifted pixel,
// every stage is exposed on the parallel tap bus.
module conv_line_shift_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic [DATA_W-1:0]       din,
    output logic [DEPTH*DATA_W-1:0] taps
);

    logic [DATA_W-1:0] r_stage [DEPTH];

    // NOTE: the stages are cleared on reset so a restarted frame never sees stale pixels in its taps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (shift_en) begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign taps[g*DATA_W +: DATA_W] = r_stage[g];
    end

endmodule

// File: rtl/conv_pixel_window_cache.sv
// Raster-order pixel fetcher that streams KER_W x KER_W windows over valid/ready.
// Optional stride-2 window decimation is enabled by defining CONV_CACHE_STRIDE_EN.
module conv_pixel_window_cache
    import conv_cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int KER_W  = 3,
    parameter int CH_NUM = 1,
    parameter int ADDR_W = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            pause,
`ifdef CONV_CACHE_STRIDE_EN
    input  logic                            stride2,
`endif
    input  logic [DATA_W-1:0]               pixel_in,
    output logic [ADDR_W-1:0]               rom_addr,
    output logic [DATA_W*KER_W*KER_W-1:0]   win_data,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [clog2(CH_NUM):0]          win_ch,
    output logic                            frame_done,
    output logic [2:0]                      current_state
);

    localparam int DEPTH = (KER_W - 1) * IMG_W + KER_W;
    localparam int WIN_W = DATA_W * KER_W * KER_W;
    localparam int COL_W = clog2(IMG_W) + 1;
    localparam int ROW_W = clog2(IMG_H) + 1;
    localparam int CH_W  = clog2(CH_NUM) + 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KER_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KER_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CH_NUM - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [CH_W-1:0]     r_ch;
    logic [WIN_W-1:0]    r_win_data;
    logic                r_win_valid;
    logic [CH_W-1:0]     r_win_ch;
    logic                r_fetch_done;

    logic                w_fetch;
    logic                w_accept;
    logic                w_col_wrap;
    logic                w_plane_wrap;
    logic                w_last_pixel;
    logic                w_stride_ok;
    logic                w_qualify;
    logic [DEPTH*DATA_W-1:0] w_taps;
    logic [WIN_W-1:0]    w_window;
    logic                w_unused_taps;

    assign w_accept     = r_win_valid && win_ready;
    assign w_fetch      = (r_state == ST_FILL || r_state == ST_RUN) && enable && !pause
                          && !(r_win_valid && !win_ready) && !r_fetch_done;
    assign w_col_wrap   = (r_col == COL_LAST);
    assign w_plane_wrap = w_col_wrap && (r_row == ROW_LAST);
    assign w_last_pixel = w_plane_wrap && (r_ch == CH_LAST);

`ifdef CONV_CACHE_STRIDE_EN
    localparam logic KM1_ODD = 1'((KER_W - 1) % 2);
    logic r_stride2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride2 <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_stride2 <= stride2;
        end
    end

    // Even offset from the first window position is a parity match on bit 0.
    assign w_stride_ok = !r_stride2 || ((r_row[0] == KM1_ODD) && (r_col[0] == KM1_ODD));
`else
    assign w_stride_ok = 1'b1;
`endif

    assign w_qualify = (r_row >= ROW_FIRST) && (r_col >= COL_FIRST) && w_stride_ok;

    conv_line_shift_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_line_buf (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_fetch),
        .din      (pixel_in),
        .taps     (w_taps)
    );

    // Only the window positions of the tap bus feed the output.
    assign w_unused_taps = ^w_taps;

    // Pixel age 0 is the incoming pixel; age a > 0 sits in buffer stage a-1.
    always_comb begin
        int age;
        age      = 0;
        w_window = '0;
        for (int r = 0; r < KER_W; r++) begin
            for (int c = 0; c < KER_W; c++) begin
                age = (KER_W - 1 - r) * IMG_W + (KER_W - 1 - c);
                if (age == 0) begin
                    w_window[win_offset(r, c, KER_W, DATA_W) +: DATA_W] = pixel_in;
                end else begin
                    w_window[win_offset(r, c, KER_W, DATA_W) +: DATA_W] = w_taps[(age - 1) * DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next-state is defaulted to the current state first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (enable) w_next_state = ST_FILL;
            ST_FILL:  if (w_fetch && w_qualify) w_next_state = ST_RUN;
            ST_RUN: begin
                if (r_fetch_done) begin
                    w_next_state = (w_accept || !r_win_valid) ? ST_DONE : ST_STALL;
                end else if (w_fetch && w_plane_wrap && !w_last_pixel) begin
                    w_next_state = ST_FILL;
                end else if (r_win_valid && !win_ready) begin
                    w_next_state = ST_STALL;
                end
            end
            ST_STALL: if (w_accept || !r_win_valid) w_next_state = r_fetch_done ? ST_DONE : ST_RUN;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_ch         <= '0;
            r_win_data   <= '0;
            r_win_valid  <= 1'b0;
            r_win_ch     <= '0;
            r_fetch_done <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_addr       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_ch         <= '0;
            r_fetch_done <= 1'b0;
        end else if (w_fetch) begin
            r_addr       <= r_addr + ADDR_W'(1);
            r_col        <= w_col_wrap ? '0 : r_col + COL_W'(1);
            if (w_col_wrap) begin
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end
            if (w_plane_wrap && !w_last_pixel) begin
                r_ch <= r_ch + CH_W'(1);
            end
            r_fetch_done <= w_last_pixel;
            r_win_data   <= w_window;
            r_win_ch     <= r_ch;
            r_win_valid  <= w_qualify;
        end else if (w_accept) begin
            r_win_valid  <= 1'b0;
        end
    end

    assign rom_addr      = r_addr;
    assign win_data      = r_win_data;
    assign win_valid     = r_win_valid;
    assign win_ch        = r_win_ch;
    assign frame_done    = (r_state == ST_DONE);
    assign current_state = r_state;

endmodule

// File: tb/tb_conv_pixel_window_cache.sv
// Directed bench for conv_pixel_window_cache: identity ROM (ROM[a] = a),
// one single-plane and one two-plane instance.
module tb_conv_pixel_window_cache;

    localparam int DATA_W = 32;
    localparam int KER_W  = 3;
    localparam int WIN_W  = DATA_W * KER_W * KER_W;

    localparam logic [WIN_W-1:0] FIRST_WIN  = {32'd0, 32'd1, 32'd2, 32'd8, 32'd9, 32'd10, 32'd16, 32'd17, 32'd18};
    localparam logic [WIN_W-1:0] SECOND_WIN = {32'd1, 32'd2, 32'd3, 32'd9, 32'd10, 32'd11, 32'd17, 32'd18, 32'd19};
    localparam logic [WIN_W-1:0] LAST_WIN   = {32'd45, 32'd46, 32'd47, 32'd53, 32'd54, 32'd55, 32'd61, 32'd62, 32'd63};
    localparam logic [WIN_W-1:0] PLANE1_WIN = {32'd64, 32'd65, 32'd66, 32'd72, 32'd73, 32'd74, 32'd80, 32'd81, 32'd82};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              enable;
    logic              pause;
    logic              win_ready;
    logic [5:0]        rom_addr;
    logic [DATA_W-1:0] pixel_in;
    logic [WIN_W-1:0]  win_data;
    logic              win_valid;
    logic [0:0]        win_ch;
    logic              frame_done;
    logic [2:0]        current_state;

    logic              d2_enable;
    logic              d2_ready;
    logic [6:0]        d2_addr;
    logic [DATA_W-1:0] d2_pixel;
    logic [WIN_W-1:0]  d2_data;
    logic              d2_valid;
    logic [1:0]        d2_ch;
    logic              d2_done;
    logic [2:0]        d2_state;

`ifdef CONV_CACHE_STRIDE_EN
    logic stride2;
    logic d2_stride2;
`endif

    assign pixel_in = 32'(rom_addr);
    assign d2_pixel = 32'(d2_addr);

    conv_pixel_window_cache #(
        .DATA_W(DATA_W), .IMG_W(8), .IMG_H(8), .KER_W(KER_W), .CH_NUM(1), .ADDR_W(6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .pause         (pause),
`ifdef CONV_CACHE_STRIDE_EN
        .stride2       (stride2),
`endif
        .pixel_in      (pixel_in),
        .rom_addr      (rom_addr),
        .win_data      (win_data),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .win_ch        (win_ch),
        .frame_done    (frame_done),
        .current_state (current_state)
    );

    conv_pixel_window_cache #(
        .DATA_W(DATA_W), .IMG_W(8), .IMG_H(8), .KER_W(KER_W), .CH_NUM(2), .ADDR_W(7)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .enable        (d2_enable),
        .pause         (1'b0),
`ifdef CONV_CACHE_STRIDE_EN
        .stride2       (d2_stride2),
`endif
        .pixel_in      (d2_pixel),
        .rom_addr      (d2_addr),
        .win_data      (d2_data),
        .win_valid     (d2_valid),
        .win_ready     (d2_ready),
        .win_ch        (d2_ch),
        .frame_done    (d2_done),
        .current_state (d2_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIN_W-1:0] cap_data [$];
    int               cap_ch   [$];
    bit               cap_done;

    // Window of an 8-wide plane starting at address base, top-left at (tr, tc).
    function automatic logic [WIN_W-1:0] exp_win(input int base, input int tr, input int tc);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < KER_W; r++) begin
            for (int c = 0; c < KER_W; c++) begin
                w[(KER_W*KER_W - 1 - (r*KER_W + c))*DATA_W +: DATA_W] = 32'(base + (tr + r)*8 + tc + c);
            end
        end
        return w;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Records every accepted window until frame_done or the cycle budget runs out.
    task automatic capture(input bit sel, input int budget);
        cap_data.delete();
        cap_ch.delete();
        cap_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!sel) begin
                if (win_valid && win_ready) begin
                    cap_data.push_back(win_data);
                    cap_ch.push_back(int'(win_ch));
                end
                if (frame_done) cap_done = 1'b1;
            end else begin
                if (d2_valid && d2_ready) begin
                    cap_data.push_back(d2_data);
                    cap_ch.push_back(int'(d2_ch));
                end
                if (d2_done) cap_done = 1'b1;
            end
            if (cap_done) break;
            step(1);
        end
    endtask

    task automatic wait_first_valid(output int edges);
        edges = 0;
        while (!win_valid && edges < 100) begin
            step(1);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; pause = 1'b0; win_ready = 1'b1;
        d2_enable = 1'b0; d2_ready = 1'b1;
`ifdef CONV_CACHE_STRIDE_EN
        stride2 = 1'b0; d2_stride2 = 1'b0;
`endif
        step(2);
        rst = 1'b0;
        tests_run++; if (rom_addr !== 6'd0) begin tests_failed++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        tests_run++; if (win_data !== '0) begin tests_failed++; $display("FAIL reset_win_data got=%h exp=0", win_data); end
        tests_run++; if (win_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
        tests_run++; if (win_ch !== 1'b0) begin tests_failed++; $display("FAIL reset_win_ch got=%0d exp=0", win_ch); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        tests_run++; if (current_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", current_state); end
    endtask

    task automatic test_full_frame();
        int edges;
        enable = 1'b1;
        win_ready = 1'b1;
        wait_first_valid(edges);
        // One edge to leave IDLE, then the 19th fetch raises the first window.
        tests_run++; if (edges != 20) begin tests_failed++; $display("FAIL first_valid_edge got=%0d exp=20", edges); end
        tests_run++; if (rom_addr !== 6'd19) begin tests_failed++; $display("FAIL first_valid_addr got=%0d exp=19", rom_addr); end
        tests_run++; if (win_data !== FIRST_WIN) begin tests_failed++; $display("FAIL first_window got=%h exp=%h", win_data, FIRST_WIN); end
        tests_run++; if (current_state !== 3'd2) begin tests_failed++; $display("FAIL first_valid_state got=%0d exp=2", current_state); end
        capture(1'b0, 500);
        tests_run++; if (cap_done !== 1'b1) begin tests_failed++; $display("FAIL frame_done_seen got=%b exp=1", cap_done); end
        tests_run++; if (cap_data.size() != 36) begin tests_failed++; $display("FAIL window_count got=%0d exp=36", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            tests_run++;
            if (cap_data[i] !== exp_win(0, i / 6, i % 6)) begin
                tests_failed++;
                $display("FAIL frame_window_%0d got=%h exp=%h", i, cap_data[i], exp_win(0, i / 6, i % 6));
            end
        end
        tests_run++; if (cap_data.size() < 36 || cap_data[35] !== LAST_WIN) begin tests_failed++; $display("FAIL last_window size=%0d exp=%h", cap_data.size(), LAST_WIN); end
        tests_run++; if (current_state !== 3'd4) begin tests_failed++; $display("FAIL done_state got=%0d exp=4", current_state); end
        enable = 1'b0;
        step(1);
        tests_run++; if (current_state !== 3'd0) begin tests_failed++; $display("FAIL after_done_state got=%0d exp=0", current_state); end
        tests_run++; if (rom_addr !== 6'd0) begin tests_failed++; $display("FAIL after_done_addr got=%0d exp=0", rom_addr); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL frame_done_pulse got=%b exp=0", frame_done); end
    endtask

    task automatic test_backpressure();
        int edges;
        enable = 1'b1;
        win_ready = 1'b1;
        wait_first_valid(edges);
        win_ready = 1'b0;
        step(5);
        tests_run++; if (win_data !== FIRST_WIN) begin tests_failed++; $display("FAIL stall_data got=%h exp=%h", win_data, FIRST_WIN); end
        tests_run++; if (rom_addr !== 6'd19) begin tests_failed++; $display("FAIL stall_addr got=%0d exp=19", rom_addr); end
        tests_run++; if (current_state !== 3'd3) begin tests_failed++; $display("FAIL stall_state got=%0d exp=3", current_state); end
        tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid got=%b exp=1", win_valid); end
        win_ready = 1'b1;
        capture(1'b0, 500);
        tests_run++; if (cap_data.size() != 36) begin tests_failed++; $display("FAIL stall_count got=%0d exp=36", cap_data.size()); end
        tests_run++; if (cap_data.size() < 2 || cap_data[0] !== FIRST_WIN) begin tests_failed++; $display("FAIL stall_release_first size=%0d exp=%h", cap_data.size(), FIRST_WIN); end
        tests_run++; if (cap_data.size() < 2 || cap_data[1] !== SECOND_WIN) begin tests_failed++; $display("FAIL stall_next_window size=%0d exp=%h", cap_data.size(), SECOND_WIN); end
        tests_run++; if (cap_done !== 1'b1) begin tests_failed++; $display("FAIL stall_frame_done got=%b exp=1", cap_done); end
        enable = 1'b0;
        step(1);
    endtask

    task automatic test_pause();
        enable = 1'b1;
        win_ready = 1'b1;
        step(6);
        pause = 1'b1;
        step(4);
        tests_run++; if (rom_addr !== 6'd5) begin tests_failed++; $display("FAIL pause_addr got=%0d exp=5", rom_addr); end
        tests_run++; if (current_state !== 3'd1) begin tests_failed++; $display("FAIL pause_state got=%0d exp=1", current_state); end
        pause = 1'b0;
        capture(1'b0, 500);
        tests_run++; if (cap_data.size() != 36) begin tests_failed++; $display("FAIL pause_count got=%0d exp=36", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            tests_run++;
            if (cap_data[i] !== exp_win(0, i / 6, i % 6)) begin
                tests_failed++;
                $display("FAIL pause_window_%0d got=%h exp=%h", i, cap_data[i], exp_win(0, i / 6, i % 6));
            end
        end
        tests_run++; if (cap_done !== 1'b1) begin tests_failed++; $display("FAIL pause_frame_done got=%b exp=1", cap_done); end
        enable = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_run();
        enable = 1'b1;
        win_ready = 1'b1;
        step(30);
        tests_run++; if (current_state !== 3'd2) begin tests_failed++; $display("FAIL pre_reset_state got=%0d exp=2", current_state); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tests_run++; if (rom_addr !== 6'd0) begin tests_failed++; $display("FAIL midrst_addr got=%0d exp=0", rom_addr); end
        tests_run++; if (win_data !== '0) begin tests_failed++; $display("FAIL midrst_data got=%h exp=0", win_data); end
        tests_run++; if (win_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid got=%b exp=0", win_valid); end
        tests_run++; if (current_state !== 3'd0) begin tests_failed++; $display("FAIL midrst_state got=%0d exp=0", current_state); end
        capture(1'b0, 500);
        tests_run++; if (cap_data.size() != 36) begin tests_failed++; $display("FAIL restart_count got=%0d exp=36", cap_data.size()); end
        tests_run++; if (cap_data.size() < 36 || cap_data[0] !== FIRST_WIN) begin tests_failed++; $display("FAIL restart_first size=%0d exp=%h", cap_data.size(), FIRST_WIN); end
        tests_run++; if (cap_data.size() < 36 || cap_data[35] !== LAST_WIN) begin tests_failed++; $display("FAIL restart_last size=%0d exp=%h", cap_data.size(), LAST_WIN); end
        tests_run++; if (cap_done !== 1'b1) begin tests_failed++; $display("FAIL restart_frame_done got=%b exp=1", cap_done); end
        enable = 1'b0;
        step(1);
    endtask

    task automatic test_two_channels();
        d2_enable = 1'b1;
        d2_ready  = 1'b1;
        capture(1'b1, 1000);
        tests_run++; if (cap_data.size() != 72) begin tests_failed++; $display("FAIL ch2_count got=%0d exp=72", cap_data.size()); end
        tests_run++; if (cap_data.size() < 72 || cap_data[35] !== LAST_WIN) begin tests_failed++; $display("FAIL ch2_plane0_last size=%0d exp=%h", cap_data.size(), LAST_WIN); end
        tests_run++; if (cap_data.size() < 72 || cap_ch[35] != 0) begin tests_failed++; $display("FAIL ch2_plane0_ch size=%0d exp=0", cap_data.size()); end
        tests_run++; if (cap_data.size() < 72 || cap_data[36] !== PLANE1_WIN) begin tests_failed++; $display("FAIL ch2_window37 size=%0d exp=%h", cap_data.size(), PLANE1_WIN); end
        tests_run++; if (cap_data.size() < 72 || cap_ch[36] != 1) begin tests_failed++; $display("FAIL ch2_window37_ch size=%0d exp=1", cap_data.size()); end
        tests_run++; if (cap_data.size() < 72 || cap_data[71] !== exp_win(64, 5, 5)) begin tests_failed++; $display("FAIL ch2_last size=%0d exp=%h", cap_data.size(), exp_win(64, 5, 5)); end
        tests_run++; if (cap_done !== 1'b1) begin tests_failed++; $display("FAIL ch2_frame_done got=%b exp=1", cap_done); end
        d2_enable = 1'b0;
        step(1);
        tests_run++; if (d2_state !== 3'd0) begin tests_failed++; $display("FAIL ch2_idle_state got=%0d exp=0", d2_state); end
        tests_run++; if (d2_addr !== 7'd0) begin tests_failed++; $display("FAIL ch2_idle_addr got=%0d exp=0", d2_addr); end
    endtask

`ifdef CONV_CACHE_STRIDE_EN
    task automatic test_stride();
        stride2 = 1'b1;
        step(1);
        enable = 1'b1;
        win_ready = 1'b1;
        capture(1'b0, 500);
        tests_run++; if (cap_data.size() != 9) begin tests_failed++; $display("FAIL stride_count got=%0d exp=9", cap_data.size()); end
        tests_run++; if (cap_data.size() < 9 || cap_data[0] !== FIRST_WIN) begin tests_failed++; $display("FAIL stride_first size=%0d exp=%h", cap_data.size(), FIRST_WIN); end
        tests_run++; if (cap_data.size() < 9 || cap_data[1] !== {32'd2, 32'd3, 32'd4, 32'd10, 32'd11, 32'd12, 32'd18, 32'd19, 32'd20}) begin tests_failed++; $display("FAIL stride_second size=%0d", cap_data.size()); end
        tests_run++; if (cap_data.size() < 9 || cap_data[8] !== {32'd36, 32'd37, 32'd38, 32'd44, 32'd45, 32'd46, 32'd52, 32'd53, 32'd54}) begin tests_failed++; $display("FAIL stride_last size=%0d", cap_data.size()); end
        tests_run++; if (cap_done !== 1'b1) begin tests_failed++; $display("FAIL stride_frame_done got=%b exp=1", cap_done); end
        enable  = 1'b0;
        stride2 = 1'b0;
        step(1);
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_pause();
        test_reset_mid_run();
        test_two_channels();
`ifdef CONV_CACHE_STRIDE_EN
        test_stride();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
